mem_master: RTL and testbench

MEM_MASTER -- requirements
Module: mem_master

---
 rtl/mem_defs.sv | 14 +
 rtl/mem_burst_ctr.sv | 40 ++++
 rtl/mem_master.sv | 121 ++++++++++++
 tb/tb_mem_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defs.sv
// rtl/mem_defs.sv - shared sizes and state encoding for the burst memory master
package mem_defs;

    localparam int word_size   = 16;
    localparam int memory_size = 256;
    localparam int addr_bits   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/mem_burst_ctr.sv
// rtl/mem_burst_ctr.sv - burst address/count registers with wrapping address
module mem_burst_ctr
    import mem_defs::*;
#(
    parameter int memory_size = 256
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [addr_bits-1:0] load_addr,
    input  logic [3:0]           load_len,
    output logic [addr_bits-1:0] addr,
    output logic [3:0]           cnt,
    output logic                 last
);

    localparam logic [addr_bits-1:0] top_addr = addr_bits'(memory_size - 1);

    // Load on request acceptance; each beat advances the address and consumes one count.
    // The count parks at zero so the last flag stays stable once the burst has ended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            cnt  <= '0;
        end else if (load) begin
            addr <= load_addr;
            cnt  <= load_len;
        end else if (step) begin
            addr <= (addr == top_addr) ? '0 : addr + 1'b1;
            if (cnt != 4'd0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign last = (cnt == 4'd0);

endmodule

// File: rtl/mem_master.sv
// rtl/mem_master.sv - read/write burst master driving a single-port memory
module mem_master
    import mem_defs::*;
#(
    parameter int word_size   = 16,
    parameter int memory_size = 256
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [word_size-1:0] req_addr,
    input  logic [3:0]           req_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [word_size-1:0] wr_data,
    output logic                 wr_done,
    output logic                 rd_valid,
    output logic [word_size-1:0] rd_data,
    output logic                 rd_last,
    output logic [word_size-1:0] mem_address,
    output logic [word_size-1:0] mem_data_in,
    output logic                 mem_write,
    input  logic [word_size-1:0] mem_data_out
);

    state_t               state;
    state_t               state_nxt;
    logic                 load;
    logic                 step;
    logic [addr_bits-1:0] addr;
    logic [3:0]           cnt;
    logic                 last;

    // Only the low address bits reach the memory; the upper request bits are dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[word_size-1:addr_bits];

    mem_burst_ctr #(
        .memory_size (memory_size)
    ) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .load_addr (req_addr[addr_bits-1:0]),
        .load_len  (req_len),
        .addr      (addr),
        .cnt       (cnt),
        .last      (last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave IDLE on acceptance, return after the beat taken at count zero.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_write ? WRITE : READ;
            READ:    if (last) state_nxt = IDLE;
            WRITE:   if (wr_valid && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshakes, memory strobe and counter controls decoded from the current state.
    always_comb begin
        req_ready = 1'b0;
        wr_ready  = 1'b0;
        mem_write = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !rst;
                load      = req_valid;
            end
            READ: begin
                step = 1'b1;
            end
            WRITE: begin
                wr_ready  = !rst;
                mem_write = wr_valid && !rst;
                step      = wr_valid;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

    assign mem_address = {{(word_size - addr_bits){1'b0}}, addr};
    assign mem_data_in = wr_data;

    // Registered read beats and the end-of-write pulse; rd_data holds between beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
            wr_done  <= 1'b0;
        end else begin
            rd_valid <= (state == READ);
            rd_last  <= (state == READ) && last;
            if (state == READ) begin
                rd_data <= mem_data_out;
            end
            wr_done  <= (state == WRITE) && wr_valid && last;
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// tb/tb_mem_master.sv - scoreboard bench for mem_master
module tb_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [3:0]  req_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic        wr_done;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_last;
    logic [15:0] mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write;
    logic [15:0] mem_data_out;

    logic        mem_init = 1'b1;
    logic [15:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;
    int mw_cnt   = 0;
    int wd_cnt   = 0;

    logic [23:0] wq[$];
    logic [16:0] rq[$];

    always #5 clk = ~clk;

    mem_master dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_done      (wr_done),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_last      (rd_last),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_data_out (mem_data_out)
    );

    // Memory model: combinational read, write on posedge while strobed.
    assign mem_data_out = mem[mem_address[7:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 | 16'(i);
        end else if (mem_write) begin
            mem[mem_address[7:0]] <= mem_data_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every memory write and read beat is matched against the scoreboard.
    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            mw_cnt++;
            if (wq.size() == 0) begin
                check("unexpected_write", 32'(mem_write), 32'd0);
            end else begin
                logic [23:0] e;
                e = wq.pop_front();
                check("wr_addr", 32'(mem_address), {16'h0, 8'h00, e[23:16]});
                check("wr_data", 32'(mem_data_in), {16'h0, e[15:0]});
            end
        end
        if (rd_valid === 1'b1) begin
            if (rq.size() == 0) begin
                check("unexpected_rd", 32'(rd_valid), 32'd0);
            end else begin
                logic [16:0] e;
                e = rq.pop_front();
                check("rd_data", 32'(rd_data), {16'h0, e[15:0]});
                check("rd_last", 32'(rd_last), {31'h0, e[16]});
            end
        end
        if (wr_done === 1'b1) wd_cnt++;
    end

    // Offer a request and hold it until accepted; returns just after the accepting edge.
    task automatic send_req(input logic w, input logic [15:0] a, input logic [3:0] l);
        int n = 0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = l;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wr_beat(input logic [7:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        wq.push_back({a, d});
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", 32'(rq.size() + wq.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int mw0;
        int wd0;
        int n;
        logic [15:0] exp_init;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        mem_init = 1'b0;
        wr_valid = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_wr_done", 32'(wr_done), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_addr", 32'(mem_address), 32'd0);
        @(posedge clk);
        #1;

        // Write burst 0x10, len 3; upper address bits must be ignored
        mw0 = mw_cnt;
        wd0 = wd_cnt;
        send_req(1'b1, 16'hAB10, 4'd3);
        for (int i = 0; i < 4; i++) wr_beat(8'h10 + 8'(i), 16'h00A0 + 16'(i));
        drain();
        check("wr1_mem_write_cycles", 32'(mw_cnt - mw0), 32'd4);
        check("wr1_done_pulses", 32'(wd_cnt - wd0), 32'd1);
        for (int i = 0; i < 4; i++) check("wr1_mem", 32'(mem[8'h10 + i]), 32'h00A0 + 32'(i));

        // Read burst of the same region, with latency checks
        for (int i = 0; i < 4; i++) rq.push_back({(i == 3), 16'h00A0 + 16'(i)});
        send_req(1'b0, 16'h0010, 4'd3);
        @(negedge clk);
        check("rd_lat_gap", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check("rd_lat_first", 32'(rd_valid), 32'd1);
        @(posedge clk);
        #1;
        drain();

        // Wrap write 0xFE, len 2
        send_req(1'b1, 16'h00FE, 4'd2);
        wr_beat(8'hFE, 16'h01FE);
        wr_beat(8'hFF, 16'h01FF);
        wr_beat(8'h00, 16'h0100);
        drain();
        check("wrap_mem_fe", 32'(mem[8'hFE]), 32'h01FE);
        check("wrap_mem_ff", 32'(mem[8'hFF]), 32'h01FF);
        check("wrap_mem_00", 32'(mem[8'h00]), 32'h0100);

        // Stall: three idle cycles mid-burst
        mw0 = mw_cnt;
        wd0 = wd_cnt;
        send_req(1'b1, 16'h0020, 4'd3);
        wr_beat(8'h20, 16'hD000);
        wr_beat(8'h21, 16'hD001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_addr", 32'(mem_address), 32'h0022);
            check("stall_mem_write", 32'(mem_write), 32'd0);
            @(posedge clk);
            #1;
        end
        wr_beat(8'h22, 16'hD002);
        wr_beat(8'h23, 16'hD003);
        drain();
        check("stall_write_cycles", 32'(mw_cnt - mw0), 32'd4);
        check("stall_done_pulses", 32'(wd_cnt - wd0), 32'd1);
        for (int i = 0; i < 4; i++) check("stall_mem", 32'(mem[8'h20 + i]), 32'hD000 + 32'(i));

        // Busy ignore: second request held during a read, accepted in the rd_last cycle
        for (int i = 0; i < 4; i++) rq.push_back({(i == 3), 16'h00A0 + 16'(i)});
        rq.push_back({1'b0, 16'h01FE});
        rq.push_back({1'b0, 16'h01FF});
        rq.push_back({1'b1, 16'h0100});
        send_req(1'b0, 16'h0010, 4'd3);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h00FE;
        req_len   = 4'd2;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 20);
        check("busy_wait_cycles", 32'(n), 32'd5);
        check("busy_accept_in_last", 32'(rd_last), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();

        // Reset during beat 2 of a 16-word write
        send_req(1'b1, 16'h0040, 4'd15);
        wr_beat(8'h40, 16'hB000);
        wr_beat(8'h41, 16'hB001);
        wr_valid = 1'b1;
        wr_data  = 16'hB002;
        #1;
        check("pre_rst_mem_write", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mem_write_drop", 32'(mem_write), 32'd0);
        check("rst_wr_ready_drop", 32'(wr_ready), 32'd0);
        check("rst_req_ready_low", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst2_req_ready", 32'(req_ready), 32'd1);
        check("rst2_mem_address", 32'(mem_address), 32'd0);
        check("rst2_mem_40", 32'(mem[8'h40]), 32'hB000);
        check("rst2_mem_41", 32'(mem[8'h41]), 32'hB001);
        for (int i = 8'h42; i < 8'h50; i++) begin
            exp_init = 16'hC000 | 16'(i);
            check("rst2_mem_untouched", 32'(mem[i]), 32'(exp_init));
        end

        check("wq_empty", 32'(wq.size()), 32'd0);
        check("rq_empty", 32'(rq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
